// File: rtl/spi_counter_ctrl.sv
// spi_counter_ctrl: SPI mode-0 slave that drives run/clear/step controls of a 25-bit counter.
// Option: define SPI_CTRL_SNAPSHOT_EN to read back a snapshot of count_in taken at the 0x20 decode.

module spi_counter_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        ce0,
    input  logic        mosi,
    output logic        miso,
    input  logic [24:0] count_in,
    output logic        count_en,
    output logic        count_clr,
    output logic [7:0]  step,
    output logic        busy,
    output logic        cmd_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_WSTEP = 3'd2;
    localparam logic [2:0] S_RDATA = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    // [0]/[1] form the synchronizer, [2] is the previous synchronized value
    logic [2:0]  sclk_sync_q, sclk_sync_d;
    logic [2:0]  ce0_sync_q, ce0_sync_d;
    logic [1:0]  mosi_sync_q, mosi_sync_d;

    logic [2:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [6:0]  rx_q, rx_d;
    logic [31:0] sh_q, sh_d;
    logic        armed_q, armed_d;
    logic        last_q, last_d;
    logic        count_en_q, count_en_d;
    logic        count_clr_q, count_clr_d;
    logic [7:0]  step_q, step_d;
    logic        cmd_err_q, cmd_err_d;

    logic        sclk_rise, sclk_fall;
    logic        ce0_s, ce0_fall, mosi_s;
    logic [7:0]  rx_byte;
    logic [24:0] rd_src;
    logic [31:0] rd_word, rd_shift;

`ifdef SPI_CTRL_SNAPSHOT_EN
    logic [24:0] snap_q, snap_d;
    assign rd_src = snap_q;
`else
    assign rd_src = count_in;
`endif

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ce0_s     = ce0_sync_q[1];
    assign ce0_fall  = ~ce0_sync_q[1] & ce0_sync_q[2];
    assign mosi_s    = mosi_sync_q[1];
    assign rx_byte   = {rx_q, mosi_s};
    assign rd_word   = {7'b0, rd_src};
    assign rd_shift  = rd_word << {byte_cnt_q, 3'b000};

    assign miso      = sh_q[31];
    assign count_en  = count_en_q;
    assign count_clr = count_clr_q;
    assign step      = step_q;
    assign busy      = ~ce0_s;
    assign cmd_err   = cmd_err_q;

    // Shift the asynchronous SPI pins into the clk domain
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], sclk};
        ce0_sync_d  = {ce0_sync_q[1:0], ce0};
        mosi_sync_d = {mosi_sync_q[0], mosi};
    end

    // Protocol FSM: command decode, step write and 32-bit readback
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rx_d        = rx_q;
        sh_d        = sh_q;
        armed_d     = armed_q;
        last_d      = last_q;
        count_en_d  = count_en_q;
        count_clr_d = 1'b0;
        step_d      = step_q;
        cmd_err_d   = cmd_err_q;
`ifdef SPI_CTRL_SNAPSHOT_EN
        snap_d      = snap_q;
`endif
        if (ce0_s) begin
            // Deselect wins over everything, including a byte completing now
            state_d = S_IDLE;
            sh_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ce0_fall) begin
                        state_d   = S_CMD;
                        bit_cnt_d = '0;
                        rx_d      = '0;
                        sh_d      = '0;
                    end
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        rx_d      = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_FLUSH;
                            case (rx_byte)
                                8'h01: begin
                                    count_en_d = 1'b1;
                                    cmd_err_d  = 1'b0;
                                end
                                8'h02: begin
                                    count_en_d = 1'b0;
                                    cmd_err_d  = 1'b0;
                                end
                                8'h03: begin
                                    count_clr_d = 1'b1;
                                    cmd_err_d   = 1'b0;
                                end
                                8'h10: begin
                                    state_d   = S_WSTEP;
                                    cmd_err_d = 1'b0;
                                end
                                8'h20: begin
                                    state_d    = S_RDATA;
                                    cmd_err_d  = 1'b0;
                                    sh_d       = {7'b0, count_in};
                                    byte_cnt_d = '0;
                                    armed_d    = 1'b0;
                                    last_d     = 1'b0;
`ifdef SPI_CTRL_SNAPSHOT_EN
                                    snap_d     = count_in;
`endif
                                end
                                default: cmd_err_d = 1'b1;
                            endcase
                        end
                    end
                end
                S_WSTEP: begin
                    if (sclk_rise) begin
                        rx_d      = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            step_d  = rx_byte;
                            state_d = S_FLUSH;
                        end
                    end
                end
                S_RDATA: begin
                    // A falling edge only advances miso once its bit was sampled
                    if (sclk_rise) begin
                        armed_d   = 1'b1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                last_d = 1'b1;
                            end
                        end
                    end else if (sclk_fall && armed_q) begin
                        armed_d = 1'b0;
                        if (last_q) begin
                            sh_d    = '0;
                            state_d = S_FLUSH;
                        end else if (bit_cnt_q == 3'd0) begin
                            sh_d = rd_shift;
                        end else begin
                            sh_d = {sh_q[30:0], 1'b0};
                        end
                    end
                end
                S_FLUSH: begin
                    sh_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    sh_d    = '0;
                end
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= 3'b000;
            ce0_sync_q  <= 3'b111;
            mosi_sync_q <= 2'b00;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            rx_q        <= '0;
            sh_q        <= '0;
            armed_q     <= 1'b0;
            last_q      <= 1'b0;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
            step_q      <= 8'h01;
            cmd_err_q   <= 1'b0;
`ifdef SPI_CTRL_SNAPSHOT_EN
            snap_q      <= '0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ce0_sync_q  <= ce0_sync_d;
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_q        <= rx_d;
            sh_q        <= sh_d;
            armed_q     <= armed_d;
            last_q      <= last_d;
            count_en_q  <= count_en_d;
            count_clr_q <= count_clr_d;
            step_q      <= step_d;
            cmd_err_q   <= cmd_err_d;
`ifdef SPI_CTRL_SNAPSHOT_EN
            snap_q      <= snap_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_counter_ctrl.sv
// tb_spi_counter_ctrl: bench for spi_counter_ctrl acting as an SPI mode-0 master.
// Honors SPI_CTRL_SNAPSHOT_EN for the expected readback when count_in moves mid-read.

module tb_spi_counter_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        ce0;
    logic        mosi;
    logic        miso;
    logic [24:0] count_in;
    logic        count_en;
    logic        count_clr;
    logic [7:0]  step;
    logic        busy;
    logic        cmd_err;

    int n_checks = 0;
    int n_fail   = 0;
    int clr_cnt  = 0;

    // Reference model of the programmer-visible controls
    logic       m_en;
    logic [7:0] m_step;
    logic       m_err;

    spi_counter_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .ce0       (ce0),
        .mosi      (mosi),
        .miso      (miso),
        .count_in  (count_in),
        .count_en  (count_en),
        .count_clr (count_clr),
        .step      (step),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (count_clr === 1'b1) clr_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_read(input logic [24:0] a,
                                             input logic [24:0] b);
        logic [31:0] wa;
        logic [31:0] wb;
        wa = {7'b0, a};
        wb = {7'b0, b};
`ifdef SPI_CTRL_SNAPSHOT_EN
        wb = wa;
`endif
        return {wa[31:24], wb[23:0]};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clock out the top nbits of tx, capturing miso just before each rise
    task automatic xfer(input logic [7:0] tx, input int nbits,
                        output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            wait_clk(5);
            rx[i] = miso;
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        ce0 = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_high();
        wait_clk(5);
        ce0 = 1'b1;
        wait_clk(6);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        logic [7:0] r;
        cs_low();
        xfer(c, 8, r);
        cs_high();
    endtask

    task automatic send_cmd2(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        cs_low();
        xfer(c, 8, r);
        xfer(d, 8, r);
        cs_high();
    endtask

    // 0x20 read; count_in switches to b before data bit index chg (-1: never)
    task automatic do_read(input logic [24:0] a, input logic [24:0] b,
                           input int chg, output logic [31:0] data);
        logic [7:0] r;
        count_in = a;
        cs_low();
        xfer(8'h20, 8, r);
        for (int i = 0; i < 32; i++) begin
            if (i == chg) count_in = b;
            mosi = 1'b0;
            wait_clk(5);
            data[31-i] = miso;
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk = 1'b0; ce0 = 1'b1; mosi = 1'b0; count_in = '0;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(3);
        m_en = 1'b0; m_step = 8'h01; m_err = 1'b0;
        n_checks++;
        if (count_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_count_en: got %b want 0", count_en);
        end
        n_checks++;
        if (count_clr !== 1'b0) begin
            n_fail++; $display("FAIL reset_count_clr: got %b want 0", count_clr);
        end
        n_checks++;
        if (step !== 8'h01) begin
            n_fail++; $display("FAIL reset_step: got %h want 01", step);
        end
        n_checks++;
        if (cmd_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err);
        end
        n_checks++;
        if (miso !== 1'b0) begin
            n_fail++; $display("FAIL reset_miso: got %b want 0", miso);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_enable();
        logic [7:0] r;
        cs_low();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_selected: got %b want 1", busy);
        end
        xfer(8'h01, 8, r);
        cs_high();
        m_en = 1'b1; m_err = 1'b0;
        n_checks++;
        if (count_en !== m_en) begin
            n_fail++; $display("FAIL enable_en: got %b want %b", count_en, m_en);
        end
        n_checks++;
        if (cmd_err !== m_err) begin
            n_fail++; $display("FAIL enable_err: got %b want %b", cmd_err, m_err);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_deselected: got %b want 0", busy);
        end
    endtask

    task automatic test_step();
        send_cmd2(8'h10, 8'h05);
        m_step = 8'h05;
        n_checks++;
        if (step !== m_step) begin
            n_fail++; $display("FAIL step_write: got %h want %h", step, m_step);
        end
        n_checks++;
        if (count_en !== m_en) begin
            n_fail++; $display("FAIL step_en_kept: got %b want %b", count_en, m_en);
        end
    endtask

    task automatic test_read();
        logic [31:0] d;
        do_read(25'h1ABCDEF, 25'h1ABCDEF, -1, d);
        wait_clk(5);
        n_checks++;
        if (miso !== 1'b0) begin
            n_fail++; $display("FAIL read_flush_miso: got %b want 0", miso);
        end
        cs_high();
        n_checks++;
        if (d !== 32'h01ABCDEF) begin
            n_fail++; $display("FAIL read_stream: got %h want 01abcdef", d);
        end
    endtask

    task automatic test_read_change();
        logic [31:0] d;
        logic [31:0] e;
        logic [24:0] a;
        logic [24:0] b;
        a = 25'h1234567;
        b = 25'h0FEDCBA;
        do_read(a, b, 4, d);
        cs_high();
        e = exp_read(a, b);
        n_checks++;
        if (d !== e) begin
            n_fail++; $display("FAIL read_midchange: got %h want %h", d, e);
        end
    endtask

    task automatic test_cmd_err();
        send_cmd(8'h7F);
        m_err = 1'b1;
        n_checks++;
        if (cmd_err !== m_err) begin
            n_fail++; $display("FAIL err_set: got %b want %b", cmd_err, m_err);
        end
        send_cmd(8'h02);
        m_err = 1'b0; m_en = 1'b0;
        n_checks++;
        if (cmd_err !== m_err) begin
            n_fail++; $display("FAIL err_clear: got %b want %b", cmd_err, m_err);
        end
        n_checks++;
        if (count_en !== m_en) begin
            n_fail++; $display("FAIL err_disable: got %b want %b", count_en, m_en);
        end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        cs_low();
        xfer(8'h10, 8, r);
        xfer(8'hAA, 4, r);
        cs_high();
        n_checks++;
        if (step !== m_step) begin
            n_fail++; $display("FAIL abort_step: got %h want %h", step, m_step);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy: got %b want 0", busy);
        end
        send_cmd(8'h01);
        m_en = 1'b1; m_err = 1'b0;
        n_checks++;
        if (count_en !== m_en) begin
            n_fail++; $display("FAIL abort_restart: got %b want %b", count_en, m_en);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] r;
        cs_low();
        xfer(8'h02, 7, r);
        mosi = 1'b0;
        wait_clk(5);
        sclk = 1'b1;
        ce0  = 1'b1;
        wait_clk(5);
        sclk = 1'b0;
        wait_clk(6);
        n_checks++;
        if (count_en !== m_en) begin
            n_fail++; $display("FAIL ce0_wins: count_en got %b want %b", count_en, m_en);
        end
    endtask

    task automatic test_clear();
        int c0;
        c0 = clr_cnt;
        send_cmd(8'h03);
        m_err = 1'b0;
        n_checks++;
        if (clr_cnt - c0 != 1) begin
            n_fail++; $display("FAIL clr_pulse: got %0d cycles want 1", clr_cnt - c0);
        end
        n_checks++;
        if (count_en !== m_en) begin
            n_fail++; $display("FAIL clr_en_kept: got %b want %b", count_en, m_en);
        end
    endtask

    task automatic test_rst_rdata();
        logic [7:0] r;
        count_in = 25'h1FFFFFF;
        cs_low();
        xfer(8'h20, 8, r);
        xfer(8'h00, 8, r);
        xfer(8'h00, 2, r);
        rst = 1'b1;
        wait_clk(2);
        m_en = 1'b0; m_step = 8'h01; m_err = 1'b0;
        n_checks++;
        if (miso !== 1'b0) begin
            n_fail++; $display("FAIL rst_rd_miso: got %b want 0", miso);
        end
        n_checks++;
        if (count_en !== m_en || step !== m_step || cmd_err !== m_err) begin
            n_fail++;
            $display("FAIL rst_rd_outputs: en=%b step=%h err=%b want %b %h %b",
                     count_en, step, cmd_err, m_en, m_step, m_err);
        end
        ce0 = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(8);
        n_checks++;
        if (miso !== 1'b0 || busy !== 1'b0 || count_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rd_after: miso=%b busy=%b clr=%b want 0 0 0",
                     miso, busy, count_clr);
        end
        send_cmd(8'h01);
        m_en = 1'b1;
        n_checks++;
        if (count_en !== m_en) begin
            n_fail++; $display("FAIL rst_rd_recover: got %b want %b", count_en, m_en);
        end
    endtask

    task automatic test_random();
        int          op;
        int          c0;
        int          want_clr;
        logic [7:0]  v8;
        logic [24:0] v25;
        logic [31:0] d;
        logic [31:0] e;
        for (int k = 0; k < 20; k++) begin
            op = int'($urandom_range(0, 5));
            c0 = clr_cnt;
            want_clr = 0;
            case (op)
                0: begin send_cmd(8'h01); m_en = 1'b1; m_err = 1'b0; end
                1: begin send_cmd(8'h02); m_en = 1'b0; m_err = 1'b0; end
                2: begin send_cmd(8'h03); want_clr = 1; m_err = 1'b0; end
                3: begin
                    v8 = 8'($urandom);
                    send_cmd2(8'h10, v8);
                    m_step = v8; m_err = 1'b0;
                end
                4: begin
                    v25 = 25'($urandom);
                    do_read(v25, v25, -1, d);
                    cs_high();
                    m_err = 1'b0;
                    e = exp_read(v25, v25);
                    n_checks++;
                    if (d !== e) begin
                        n_fail++; $display("FAIL rand_read %0d: got %h want %h", k, d, e);
                    end
                end
                default: begin
                    v8 = 8'($urandom);
                    while (v8 == 8'h01 || v8 == 8'h02 || v8 == 8'h03 ||
                           v8 == 8'h10 || v8 == 8'h20) v8 = 8'($urandom);
                    send_cmd(v8);
                    m_err = 1'b1;
                end
            endcase
            n_checks++;
            if (count_en !== m_en || step !== m_step || cmd_err !== m_err) begin
                n_fail++;
                $display("FAIL rand_state %0d op%0d: en=%b step=%h err=%b want %b %h %b",
                         k, op, count_en, step, cmd_err, m_en, m_step, m_err);
            end
            n_checks++;
            if (clr_cnt - c0 != want_clr) begin
                n_fail++;
                $display("FAIL rand_clr %0d: got %0d want %0d", k, clr_cnt - c0, want_clr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_step();
        test_read();
        test_read_change();
        test_cmd_err();
        test_abort();
        test_simultaneous();
        test_clear();
        test_rst_rdata();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_counter_ctrl.md
SPI_COUNTER_CTRL -- requirements
Module: spi_counter_ctrl

Interface
REQ-001 SHALL have these ports, each listed as name, direction, width, meaning, with clock and reset first.
- clk, in, 1, system clock; all state is on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- sclk, in, 1, SPI clock from master; asynchronous to clk.
- ce0, in, 1, SPI chip enable, active-low; asynchronous to clk.
- mosi, in, 1, master out slave in; asynchronous to clk.
- miso, out, 1, master in slave out.
- count_in, in, 25, current counter value.
- count_en, out, 1, counter run enable (level).
- count_clr, out, 1, counter clear, one-clk pulse.
- step, out, 8, counter increment value.
- busy, out, 1, high while ce0 is synchronized low.
- cmd_err, out, 1, sticky flag for an unknown command.
REQ-002 SHALL have one clock (clk) and one reset (rst); rst is synchronous and active-high.

Function
REQ-003 SHALL pass sclk, ce0 and mosi each through a 2-flop synchronizer; edges SHALL be detected on the synchronized sclk; clk frequency >= 8x sclk.
REQ-004 SHALL operate in SPI mode 0: mosi sampled on the synchronized sclk rising edge; miso changed on the falling edge; bytes are MSB first.
REQ-005 SHALL implement FSM states IDLE, CMD, WSTEP, RDATA, FLUSH.
REQ-006 IDLE->CMD when synchronized ce0 falls; bit counter cleared; miso=0.
REQ-007 In CMD, on the 8th rising edge, the byte SHALL be decoded in the same clk:
- 0x01: count_en<=1; go to FLUSH.
- 0x02: count_en<=0; go to FLUSH.
- 0x03: count_clr pulses 1 clk; go to FLUSH.
- 0x10: go to WSTEP.
- 0x20: load the 32-bit shift register with {7'b0,count_in}; go to RDATA.
- any other value: cmd_err<=1; go to FLUSH.
REQ-008 Any valid command SHALL clear cmd_err.
REQ-009 In WSTEP, on the 8th rising edge, step SHALL take the received byte, then go to FLUSH.
REQ-010 In RDATA, miso SHALL present bit 31 within 3 clk of entry and shift one bit per falling edge; after 32 bits miso=0 and the FSM goes to FLUSH.
REQ-011 In FLUSH, clocks SHALL be ignored and miso=0 until ce0 rises.
REQ-012 Synchronized ce0 high in any state SHALL force IDLE on the next clk.
- A partial byte SHALL be discarded with no side effects; step and count_en are unchanged.
- A read cut short in RDATA simply ends.
REQ-013 busy SHALL equal the inverted synchronized ce0.
REQ-014 The bit counter SHALL be 3 bits and wrap 7->0 at each byte boundary.
REQ-015 Simultaneous ce0 rise and 8th sclk rise in the same clk: ce0 SHALL win and the byte is discarded.

Reset
REQ-016 rst SHALL set the following:
- FSM=IDLE, count_en=0, count_clr=0.
- step=8'h01, cmd_err=0, miso=0.
- shift registers=0, synchronizers=idle (sclk 0, ce0 1).
REQ-017 rst asserted mid-transaction SHALL abort it.
- After rst deasserts, the FSM stays in IDLE until a new ce0 falling edge is seen.

Configuration
REQ-018 Macro SPI_CTRL_SNAPSHOT_EN SHALL control how read data is captured.
- Defined: count_in is captured into a 25-bit snapshot at the 0x20 decode, and all four read bytes come from that snapshot.
- Undefined: each read byte is reloaded from the live count_in at its byte boundary, so bytes may be inconsistent.

Verification
REQ-019 Bench SHALL cover these scenarios:
- rst, then send 0x01 -> count_en=1 after ce0 rises; cmd_err=0.
- Send 0x10 then 0x05 -> step=8'h05; count_en unchanged.
- count_in=25'h1ABCDEF, send 0x20 plus 32 clocks -> miso stream 0x01ABCDEF.
- With SPI_CTRL_SNAPSHOT_EN: count_in changes mid-read -> the stream is still the original value.
- Send 0x7F -> cmd_err=1; then send 0x02 -> cmd_err=0 and count_en=0.
- Send 0x10, then raise ce0 after 4 data bits -> step stays 8'h01 and the FSM is in IDLE.
- Send 0x03 -> count_clr is high for exactly 1 clk.
- Assert rst during RDATA -> miso=0 and all outputs return to reset values.
